// File: rtl/arbiter_lock_pkg.sv
// arbiter_lock_pkg
//   Shared types and helpers for the grant-lock stage.
//   - state_t        : lock FSM state (IDLE / OWNED)
//   - lowest_set()   : isolate the lowest set bit of a vector (one-hot result)
//   - onehot_to_idx(): binary index of the set bit of a one-hot vector
//   Helpers work on a fixed MAXN-bit vector; callers zero-extend their
//   narrower vectors and keep the low bits of the result.
package arbiter_lock_pkg;

    localparam int MAXN  = 64;
    localparam int MAXIW = 6;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    // Two's-complement trick: v & -v keeps only the lowest set bit.
    function automatic logic [MAXN-1:0] lowest_set(input logic [MAXN-1:0] v);
        return v & (~v + {{(MAXN-1){1'b0}}, 1'b1});
    endfunction

    // OR of the indices of every set bit; exact for a one-hot input.
    function automatic logic [MAXIW-1:0] onehot_to_idx(input logic [MAXN-1:0] v);
        logic [MAXIW-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAXN; i++) begin
            if (v[i]) idx = idx | MAXIW'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/arbiter_lock_if.sv
// arbiter_lock_if
//   Handshake bundle between the upstream priority arbiter / requesters
//   and the grant-lock stage.
//   master : drives grant_in, request, done; observes the locked outputs
//   slave  : the lock stage itself
//   Signals:
//     grant_in [N]  one-hot grant from upstream arbiter
//     request  [N]  raw request vector
//     done          completion strobe from the current owner
//     grant    [N]  locked one-hot grant
//     grant_id [IW] index of the locked owner
//     busy          lock held
//     timeout       one-cycle forced-release pulse
interface arbiter_lock_if #(
    parameter int N  = 16,
    parameter int IW = 4
);
    import arbiter_lock_pkg::*;

    logic [N-1:0]  grant_in;
    logic [N-1:0]  request;
    logic          done;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_id;
    logic          busy;
    logic          timeout;

    modport master (
        output grant_in, request, done,
        input  grant, grant_id, busy, timeout
    );

    modport slave (
        input  grant_in, request, done,
        output grant, grant_id, busy, timeout
    );

endinterface

// File: rtl/arbiter_lock_onehot_enc.sv
// onehot_enc
//   Combinational: isolates the lowest set bit of i_vec and encodes its index.
//   Ports:
//     i_vec    [N]  input vector (may have several bits set)
//     o_onehot [N]  lowest set bit only (zero if i_vec is zero)
//     o_idx    [IW] binary index of o_onehot (zero if i_vec is zero)
module onehot_enc
    import arbiter_lock_pkg::*;
#(
    parameter int N  = 16,
    parameter int IW = 4
) (
    input  logic [N-1:0]  i_vec,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx
);

    logic [MAXN-1:0]  w_vec_ext;
    logic [MAXN-1:0]  w_low_ext;
    logic [MAXIW-1:0] w_idx_ext;

    assign w_vec_ext = MAXN'(i_vec);
    assign w_low_ext = lowest_set(w_vec_ext);
    assign w_idx_ext = onehot_to_idx(w_low_ext);

    assign o_onehot = w_low_ext[N-1:0];
    assign o_idx    = w_idx_ext[IW-1:0];

    // High bits of the widened helpers are always zero here; sink them.
    generate
        if (N < MAXN) begin : g_sink_vec
            logic w_unused_vec;
            assign w_unused_vec = ^w_low_ext[MAXN-1:N];
        end
        if (IW < MAXIW) begin : g_sink_idx
            logic w_unused_idx;
            assign w_unused_idx = ^w_idx_ext[MAXIW-1:IW];
        end
    endgenerate

endmodule

// File: rtl/arbiter_lock.sv
// arbiter_lock
//   Registers the one-hot grant of an upstream fixed-priority arbiter and
//   holds it until the owner signals done, drops its request, or holds for
//   TMO consecutive cycles (TMO=0 disables the limit). One idle bubble
//   cycle always separates two owners.
//   Ports:
//     clk   clock (rising edge)
//     rst   synchronous active-high reset
//     bus   arbiter_lock_if.slave: grant_in/request/done in,
//           grant/grant_id/busy/timeout out (all registered)
module arbiter_lock
    import arbiter_lock_pkg::*;
#(
    parameter int N   = 16,
    parameter int IW  = 4,
    parameter int TMO = 64
) (
    input  logic         clk,
    input  logic         rst,
    arbiter_lock_if.slave bus
);

    localparam int CW_RAW = (TMO > 0) ? $clog2(TMO + 1) : 1;
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] CNT_MAX = CW'((TMO > 0) ? (TMO - 1) : 0);

    state_t         r_state;
    logic [N-1:0]   r_grant;
    logic [IW-1:0]  r_grant_id;
    logic           r_busy;
    logic           r_timeout;
    logic [CW-1:0]  r_cnt;

    logic [N-1:0]   w_cap_oh;
    logic [IW-1:0]  w_cap_idx;
    logic           w_rel_user;
    logic           w_rel_tmo;

    onehot_enc #(.N(N), .IW(IW)) u_enc (
        .i_vec    (bus.grant_in),
        .o_onehot (w_cap_oh),
        .o_idx    (w_cap_idx)
    );

    // Owner-driven release wins over the timeout on the same cycle.
    assign w_rel_user = bus.done || !bus.request[r_grant_id];
    assign w_rel_tmo  = (TMO != 0) && (r_cnt == CNT_MAX) && !w_rel_user;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|bus.grant_in) begin
                        r_state    <= OWNED;
                        r_grant    <= w_cap_oh;
                        r_grant_id <= w_cap_idx;
                        r_busy     <= 1'b1;
                        r_cnt      <= '0;
                    end
                end
                OWNED: begin
                    if (w_rel_user || w_rel_tmo) begin
                        // Returning to IDLE gives the mandatory bubble cycle.
                        r_state    <= IDLE;
                        r_grant    <= '0;
                        r_grant_id <= '0;
                        r_busy     <= 1'b0;
                        r_cnt      <= '0;
                        r_timeout  <= w_rel_tmo;
                    end else if ((TMO != 0) && (r_cnt != CNT_MAX)) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.grant    = r_grant;
    assign bus.grant_id = r_grant_id;
    assign bus.busy     = r_busy;
    assign bus.timeout  = r_timeout;

endmodule

// File: tb/tb_arbiter_lock.sv
module tb_arbiter_lock;

    localparam int N   = 16;
    localparam int IW  = 4;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    arbiter_lock_if #(.N(N), .IW(IW)) bus ();

    arbiter_lock #(.N(N), .IW(IW), .TMO(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: which requester owns the resource and how many
    // cycles it has been shown the grant so far.
    int   m_owner = -1;
    int   m_held  = 0;
    logic m_tmo   = 1'b0;

    function automatic int lowest_index(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    function automatic logic [IW-1:0] exp_id();
        return (m_owner >= 0) ? IW'(m_owner) : '0;
    endfunction

    // One clock edge: advance the model with the inputs seen at the edge,
    // then leave time for the DUT outputs to settle before sampling.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_owner = -1; m_held = 0; m_tmo = 1'b0;
        end else if (m_owner < 0) begin
            m_tmo = 1'b0;
            if (bus.grant_in != '0) begin
                m_owner = lowest_index(bus.grant_in);
                m_held  = 1;
            end
        end else if (bus.done || !bus.request[m_owner]) begin
            m_owner = -1; m_held = 0; m_tmo = 1'b0;
        end else if (m_held == TMO) begin
            m_owner = -1; m_held = 0; m_tmo = 1'b1;
        end else begin
            m_held++;
            m_tmo = 1'b0;
        end
        #1;
    endtask

    task automatic set_in(input logic [N-1:0] g, input logic [N-1:0] r, input logic d);
        bus.grant_in = g;
        bus.request  = r;
        bus.done     = d;
    endtask

    task automatic go_idle();
        set_in('0, '0, 1'b0);
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(16'h0004, 16'h0004, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.grant !== 16'h0 || bus.grant_id !== 4'd0 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: grant=%h id=%0d busy=%b tmo=%b, want all 0", i, bus.grant, bus.grant_id, bus.busy, bus.timeout);
            end
        end
        rst = 1'b0;
        checks++;
        if (bus.grant !== 16'h0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_cycle: grant=%h busy=%b, want 0000/0", bus.grant, bus.busy);
        end
        tick();
        checks++;
        if (bus.grant !== 16'h0004 || bus.grant_id !== 4'd2 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_capture: grant=%h id=%0d busy=%b, want 0004/2/1", bus.grant, bus.grant_id, bus.busy);
        end
        go_idle();
    endtask

    task automatic test_lock_hold();
        set_in(16'h0010, 16'h0010, 1'b0);
        tick();
        checks++;
        if (bus.grant !== 16'h0010 || bus.grant_id !== 4'd4 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL lock_capture: grant=%h id=%0d busy=%b, want 0010/4/1", bus.grant, bus.grant_id, bus.busy);
        end
        set_in(16'h0001, 16'h0011, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.grant !== 16'h0010 || bus.grant_id !== 4'd4) begin
                errors++;
                $display("FAIL lock_frozen cyc%0d: grant=%h id=%0d, want 0010/4", i, bus.grant, bus.grant_id);
            end
        end
        tick();
        bus.done = 1'b1;
        tick();
        checks++;
        if (bus.grant !== 16'h0 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL lock_done_release: grant=%h busy=%b tmo=%b, want 0000/0/0", bus.grant, bus.busy, bus.timeout);
        end
        bus.done = 1'b0;
        tick();
        checks++;
        if (bus.grant !== 16'h0001 || bus.grant_id !== 4'd0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL lock_next_owner: grant=%h id=%0d busy=%b, want 0001/0/1", bus.grant, bus.grant_id, bus.busy);
        end
        go_idle();
    endtask

    task automatic test_request_drop();
        set_in(16'h0010, 16'h0010, 1'b0);
        tick();
        tick();
        tick();
        set_in(16'h0000, 16'h0000, 1'b0);
        tick();
        checks++;
        if (bus.grant !== 16'h0 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL req_drop: grant=%h busy=%b tmo=%b, want 0000/0/0", bus.grant, bus.busy, bus.timeout);
        end
        go_idle();
    endtask

    task automatic test_timeout();
        set_in(16'h8000, 16'h8000, 1'b0);
        tick();
        for (int i = 0; i < TMO; i++) begin
            checks++;
            if (bus.grant !== 16'h8000 || bus.grant_id !== 4'd15 || bus.timeout !== 1'b0) begin
                errors++;
                $display("FAIL tmo_hold cyc%0d: grant=%h id=%0d tmo=%b, want 8000/15/0", i, bus.grant, bus.grant_id, bus.timeout);
            end
            tick();
        end
        checks++;
        if (bus.grant !== 16'h0 || bus.busy !== 1'b0 || bus.timeout !== 1'b1) begin
            errors++;
            $display("FAIL tmo_pulse: grant=%h busy=%b tmo=%b, want 0000/0/1", bus.grant, bus.busy, bus.timeout);
        end
        tick();
        checks++;
        if (bus.grant !== 16'h8000 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL tmo_recapture: grant=%h tmo=%b, want 8000/0", bus.grant, bus.timeout);
        end
        go_idle();
    endtask

    task automatic test_precedence();
        set_in(16'h0002, 16'h0002, 1'b0);
        tick();
        for (int i = 1; i < TMO; i++) tick();
        bus.done = 1'b1;
        tick();
        checks++;
        if (bus.grant !== 16'h0 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL prec_done_over_tmo: grant=%h busy=%b tmo=%b, want 0000/0/0", bus.grant, bus.busy, bus.timeout);
        end
        go_idle();
        set_in(16'h0C00, 16'h0C00, 1'b0);
        tick();
        checks++;
        if (bus.grant !== 16'h0400 || bus.grant_id !== 4'd10 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL malformed: grant=%h id=%0d busy=%b, want 0400/10/1", bus.grant, bus.grant_id, bus.busy);
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        set_in(16'h0080, 16'h0080, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (bus.grant !== 16'h0 || bus.grant_id !== 4'd0 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: grant=%h id=%0d busy=%b tmo=%b, want all 0", bus.grant, bus.grant_id, bus.busy, bus.timeout);
        end
        rst = 1'b0;
        tick();
        for (int i = 0; i < TMO; i++) begin
            checks++;
            if (bus.grant !== 16'h0080 || bus.grant_id !== 4'd7 || bus.timeout !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_hold cyc%0d: grant=%h id=%0d tmo=%b, want 0080/7/0", i, bus.grant, bus.grant_id, bus.timeout);
            end
            tick();
        end
        checks++;
        if (bus.timeout !== 1'b1 || bus.grant !== 16'h0) begin
            errors++;
            $display("FAIL rst_mid_tmo: grant=%h tmo=%b, want 0000/1", bus.grant, bus.timeout);
        end
        go_idle();
    endtask

    task automatic test_random();
        logic [N-1:0] req;
        logic [N-1:0] g;
        for (int c = 0; c < 600; c++) begin
            // Sparse requests so owners come and go and timeouts still occur.
            req = '0;
            if ($urandom_range(0, 9) != 0) req[$urandom_range(N-1, 0)] = 1'b1;
            if ($urandom_range(0, 3) == 0) req[$urandom_range(N-1, 0)] = 1'b1;
            if ($urandom_range(0, 4) == 0 && m_owner >= 0) req[m_owner] = 1'b1;
            if ($urandom_range(0, 1) == 0 && m_owner >= 0) req[m_owner] = 1'b1;
            g = '0;
            if (lowest_index(req) >= 0) g[lowest_index(req)] = 1'b1;
            if ($urandom_range(0, 9) == 0) g = req;
            set_in(g, req, ($urandom_range(0, 7) == 0));
            rst = ($urandom_range(0, 99) == 0);
            tick();
            checks++;
            if (bus.grant !== exp_grant() || bus.grant_id !== exp_id() || bus.busy !== (m_owner >= 0) || bus.timeout !== m_tmo) begin
                errors++;
                $display("FAIL random cyc%0d: grant=%h id=%0d busy=%b tmo=%b, want %h/%0d/%b/%b", c, bus.grant, bus.grant_id, bus.busy, bus.timeout, exp_grant(), exp_id(), (m_owner >= 0), m_tmo);
            end
        end
        rst = 1'b0;
        go_idle();
    endtask

    initial begin
        set_in('0, '0, 1'b0);
        test_reset();
        test_lock_hold();
        test_request_drop();
        test_timeout();
        test_precedence();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
